// File: rtl/xtea_pkg.sv
// xtea_pkg: shared constants and types for the XTEA mode core.
//   DELTA       - XTEA key-schedule constant.
//   mode_t      - chaining mode encoding (reserved code behaves as ECB).
//   state_t     - control FSM states.
//   delta_times - DELTA * R mod 2^32, the starting sum for an R-round decrypt.
package xtea_pkg;

  localparam logic [31:0] DELTA = 32'h9E3779B9;

  typedef enum logic [1:0] {
    MODE_ECB  = 2'b00,
    MODE_CBC  = 2'b01,
    MODE_CTR  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [31:0] delta_times(input logic [6:0] r);
    return DELTA * {25'd0, r};
  endfunction

endpackage

// File: rtl/xtea_round.sv
// xtea_round: one combinational XTEA round (both half-updates).
//   v0_in/v1_in/sum_in - working state entering the round
//   key                - 128-bit key, key[127:96] is k[0]
//   encdec             - 1 encrypt (sum counts up), 0 decrypt (sum counts down)
//   v0_out/v1_out/sum_out - working state leaving the round
module xtea_round
  import xtea_pkg::*;
(
  input  logic [31:0]  v0_in,
  input  logic [31:0]  v1_in,
  input  logic [31:0]  sum_in,
  input  logic [127:0] key,
  input  logic         encdec,
  output logic [31:0]  v0_out,
  output logic [31:0]  v1_out,
  output logic [31:0]  sum_out
);

  function automatic logic [31:0] key_word(input logic [127:0] k, input logic [1:0] idx);
    case (idx)
      2'd0:    return k[127:96];
      2'd1:    return k[95:64];
      2'd2:    return k[63:32];
      default: return k[31:0];
    endcase
  endfunction

  function automatic logic [31:0] mix(input logic [31:0] x);
    return ((x << 4) ^ (x >> 5)) + x;
  endfunction

  logic [31:0] v0_t, v1_t, sum_t;

  // Decrypt undoes the encrypt half-steps in reverse order: v1 first with
  // the current sum, then v0 with the already-decremented sum.
  always_comb begin
    if (encdec) begin
      sum_t = sum_in + DELTA;
      v0_t  = v0_in + (mix(v1_in) ^ (sum_in + key_word(key, sum_in[1:0])));
      v1_t  = v1_in + (mix(v0_t) ^ (sum_t + key_word(key, sum_t[12:11])));
    end else begin
      sum_t = sum_in - DELTA;
      v1_t  = v1_in - (mix(v0_in) ^ (sum_in + key_word(key, sum_in[12:11])));
      v0_t  = v0_in - (mix(v1_t) ^ (sum_t + key_word(key, sum_t[1:0])));
    end
  end

  assign v0_out  = v0_t;
  assign v1_out  = v1_t;
  assign sum_out = sum_t;

endmodule

// File: rtl/xtea_mode_core.sv
// xtea_mode_core: iterative XTEA engine with ECB/CBC/CTR chaining.
//   UNROLL         - rounds per clock (1, 2, 4, 8)
//   DEFAULT_ROUNDS - round count when rounds==0 and use_default==1
// Ports:
//   clk, reset                - clock, synchronous active-high reset
//   key, mode, encdec, rounds, use_default - block parameters, sampled at accept
//   iv, iv_load               - chain/counter load (honoured only in IDLE)
//   in_valid/in_ready/in_block    - input block stream
//   out_valid/out_ready/out_block - result stream
//   busy                      - high while a block is in RUN or DONE
module xtea_mode_core
  import xtea_pkg::*;
#(
  parameter int UNROLL         = 1,
  parameter int DEFAULT_ROUNDS = 32
)(
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] key,
  input  logic [63:0]  iv,
  input  logic         iv_load,
  input  logic [1:0]   mode,
  input  logic         encdec,
  input  logic [5:0]   rounds,
  input  logic         use_default,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_block,
  output logic         busy
);

  state_t       state;
  logic [31:0]  v0, v1, sum;
  logic [6:0]   cnt;
  logic [127:0] key_r;
  mode_t        mode_r;
  logic         enc_r;
  logic [63:0]  blk_r;
  logic [63:0]  chain;

  logic         accept;
  mode_t        mode_in;
  logic         enc_in;
  logic [63:0]  cipher_in;
  logic [6:0]   r_eff, n_cyc, r_up;
  logic [63:0]  cipher, result, chain_next;

  assign in_ready = (state == ST_IDLE) && !iv_load && !reset;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != ST_IDLE);
  assign mode_in  = mode_t'(mode);
  // CTR only ever runs the cipher forward to make keystream.
  assign enc_in   = (mode_in == MODE_CTR) ? 1'b1 : encdec;

  // Round count: 0 selects 64 or the default; then rounded up to whole cycles.
  always_comb begin
    if (rounds != 6'd0)   r_eff = {1'b0, rounds};
    else if (use_default) r_eff = 7'(DEFAULT_ROUNDS);
    else                  r_eff = 7'd64;
  end
  assign n_cyc = (r_eff + 7'(UNROLL - 1)) / 7'(UNROLL);
  assign r_up  = 7'(n_cyc * 7'(UNROLL));

  always_comb begin
    case (mode_in)
      MODE_CBC: cipher_in = encdec ? (in_block ^ chain) : in_block;
      MODE_CTR: cipher_in = chain;
      default:  cipher_in = in_block;
    endcase
  end

  // Unrolled round chain between the working registers
  logic [31:0] v0_c  [0:UNROLL];
  logic [31:0] v1_c  [0:UNROLL];
  logic [31:0] sum_c [0:UNROLL];

  assign v0_c[0]  = v0;
  assign v1_c[0]  = v1;
  assign sum_c[0] = sum;

  for (genvar g = 0; g < UNROLL; g++) begin : g_round
    xtea_round u_round (
      .v0_in  (v0_c[g]),
      .v1_in  (v1_c[g]),
      .sum_in (sum_c[g]),
      .key    (key_r),
      .encdec (enc_r),
      .v0_out (v0_c[g+1]),
      .v1_out (v1_c[g+1]),
      .sum_out(sum_c[g+1])
    );
  end

  assign cipher = {v0_c[UNROLL], v1_c[UNROLL]};

  always_comb begin
    result     = cipher;
    chain_next = chain;
    case (mode_r)
      MODE_CBC: begin
        if (enc_r) begin
          chain_next = cipher;
        end else begin
          result     = cipher ^ chain;
          chain_next = blk_r;
        end
      end
      MODE_CTR: begin
        result     = blk_r ^ cipher;
        chain_next = chain + 64'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      v0        <= '0;
      v1        <= '0;
      sum       <= '0;
      cnt       <= '0;
      key_r     <= '0;
      mode_r    <= MODE_ECB;
      enc_r     <= 1'b0;
      blk_r     <= '0;
      chain     <= '0;
      out_valid <= 1'b0;
      out_block <= '0;
    end else begin
      case (state)
        // IDLE: iv load has priority over block accept
        ST_IDLE: begin
          if (iv_load) begin
            chain <= iv;
          end else if (accept) begin
            v0     <= cipher_in[63:32];
            v1     <= cipher_in[31:0];
            sum    <= enc_in ? 32'd0 : delta_times(r_up);
            cnt    <= n_cyc;
            key_r  <= key;
            mode_r <= mode_in;
            enc_r  <= enc_in;
            blk_r  <= in_block;
            state  <= ST_RUN;
          end
        end
        // RUN: the final iteration also registers the chained result
        ST_RUN: begin
          v0  <= v0_c[UNROLL];
          v1  <= v1_c[UNROLL];
          sum <= sum_c[UNROLL];
          cnt <= cnt - 7'd1;
          if (cnt == 7'd1) begin
            out_block <= result;
            chain     <= chain_next;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        // DONE: hold result until taken
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
